// File: rtl/axi_riscv_lrsc_initiator.sv
// axi_riscv_lrsc_initiator
// Turns a single-outstanding core request port (LOAD/STORE/LR/SC) into single-beat AXI4
// master transactions. LR is issued as a locked read, SC as a locked write. The slave's
// EXOKAY/OKAY answer is reported back as reservation / store-conditional success.
//
// Handshake semantics (all channels, both sides): a transfer happens on a rising clk_i edge
// where valid and ready are both 1. Once this block raises a valid it holds the valid and its
// payload stable until that transfer; it never waits for the peer's ready before asserting
// valid. The ready outputs depend only on the FSM state, never on the peer's valid.

module axi_riscv_lrsc_initiator #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0,
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // core request port
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_op_i,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]                req_size_i,
    input  logic [AXI_DATA_WIDTH-1:0] req_wdata_i,
    input  logic [AXI_STRB_WIDTH-1:0] req_strb_i,
    // core response port
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] rsp_data_o,
    output logic                      rsp_excl_ok_o,
    output logic                      rsp_err_o,
    // AXI AR
    output logic [AXI_ADDR_WIDTH-1:0] mst_ar_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   mst_ar_id_o,
    output logic [2:0]                mst_ar_size_o,
    output logic                      mst_ar_lock_o,
    output logic                      mst_ar_valid_o,
    input  logic                      mst_ar_ready_i,
    // AXI R
    input  logic [AXI_DATA_WIDTH-1:0] mst_r_data_i,
    input  logic [1:0]                mst_r_resp_i,
    input  logic                      mst_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   mst_r_id_i,
    input  logic                      mst_r_valid_i,
    output logic                      mst_r_ready_o,
    // AXI AW
    output logic [AXI_ADDR_WIDTH-1:0] mst_aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   mst_aw_id_o,
    output logic [2:0]                mst_aw_size_o,
    output logic                      mst_aw_lock_o,
    output logic                      mst_aw_valid_o,
    input  logic                      mst_aw_ready_i,
    // AXI W
    output logic [AXI_DATA_WIDTH-1:0] mst_w_data_o,
    output logic [AXI_STRB_WIDTH-1:0] mst_w_strb_o,
    output logic                      mst_w_last_o,
    output logic                      mst_w_valid_o,
    input  logic                      mst_w_ready_i,
    // AXI B
    input  logic [1:0]                mst_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   mst_b_id_i,
    input  logic                      mst_b_valid_i,
    output logic                      mst_b_ready_o,
    // debug: current FSM state
    output logic [2:0]                dbg_state_o
);

    localparam int MAX_SIZE = $clog2(AXI_STRB_WIDTH);
    localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LR    = 2'b10;
    localparam logic [1:0] OP_SC    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AWW  = 3'd3,
        S_B    = 3'd4,
        S_RSP  = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [1:0]                op_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [2:0]                size_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_STRB_WIDTH-1:0] strb_q;
    logic                      aw_sent_q;
    logic                      w_sent_q;
    logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
    logic                      rsp_excl_ok_q;
    logic                      rsp_err_q;

    logic [AXI_ADDR_WIDTH-1:0] size_mask;
    logic                      excl_reject;
    logic                      req_fire;

    // Exclusive accesses must be naturally aligned and fit in one data beat; otherwise they
    // are answered locally with an error and never reach the bus.
    always_comb begin
        size_mask   = (AXI_ADDR_WIDTH'(1) << req_size_i) - AXI_ADDR_WIDTH'(1);
        excl_reject = req_op_i[1] &&
                      (((req_addr_i & size_mask) != '0) || (req_size_i > 3'(MAX_SIZE)));
    end

    assign req_fire = req_valid_i && req_ready_o;

    // State register; reset drops every valid at once because all valids decode from it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d        = state_q;
        req_ready_o    = 1'b0;
        mst_ar_valid_o = 1'b0;
        mst_r_ready_o  = 1'b0;
        mst_aw_valid_o = 1'b0;
        mst_w_valid_o  = 1'b0;
        mst_b_ready_o  = 1'b0;
        rsp_valid_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (excl_reject) begin
                        state_d = S_RSP;
                    end else if (req_op_i[0]) begin
                        state_d = S_AWW;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                mst_ar_valid_o = 1'b1;
                if (mst_ar_ready_i) state_d = S_R;
            end
            S_R: begin
                mst_r_ready_o = 1'b1;
                if (mst_r_valid_i) state_d = S_RSP;
            end
            S_AWW: begin
                // AW and W are independent: each is offered until its own transfer.
                mst_aw_valid_o = !aw_sent_q;
                mst_w_valid_o  = !w_sent_q;
                if ((aw_sent_q || mst_aw_ready_i) && (w_sent_q || mst_w_ready_i)) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                mst_b_ready_o = 1'b1;
                if (mst_b_valid_i) state_d = S_RSP;
            end
            S_RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, AW/W sent tracking and response capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q          <= OP_LOAD;
            addr_q        <= '0;
            size_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            aw_sent_q     <= 1'b0;
            w_sent_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_excl_ok_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            if (req_fire) begin
                op_q      <= req_op_i;
                addr_q    <= req_addr_i;
                size_q    <= req_size_i;
                wdata_q   <= req_wdata_i;
                strb_q    <= req_strb_i;
                aw_sent_q <= 1'b0;
                w_sent_q  <= 1'b0;
                if (excl_reject) begin
                    rsp_data_q    <= '0;
                    rsp_excl_ok_q <= 1'b0;
                    rsp_err_q     <= 1'b1;
                end
            end
            if (state_q == S_AWW) begin
                if (mst_aw_ready_i) aw_sent_q <= 1'b1;
                if (mst_w_ready_i)  w_sent_q  <= 1'b1;
            end
            // EXOKAY counts as success only for the exclusive flavour of each direction.
            if (state_q == S_R && mst_r_valid_i) begin
                rsp_data_q    <= mst_r_data_i;
                rsp_err_q     <= mst_r_resp_i[1];
                rsp_excl_ok_q <= (op_q == OP_LR) && (mst_r_resp_i == 2'b01);
            end
            if (state_q == S_B && mst_b_valid_i) begin
                rsp_data_q    <= '0;
                rsp_err_q     <= mst_b_resp_i[1];
                rsp_excl_ok_q <= (op_q == OP_SC) && (mst_b_resp_i == 2'b01);
            end
        end
    end

    assign mst_ar_addr_o = addr_q;
    assign mst_ar_id_o   = ID_VAL;
    assign mst_ar_size_o = size_q;
    assign mst_ar_lock_o = (op_q == OP_LR);

    assign mst_aw_addr_o = addr_q;
    assign mst_aw_id_o   = ID_VAL;
    assign mst_aw_size_o = size_q;
    assign mst_aw_lock_o = (op_q == OP_SC);

    assign mst_w_data_o  = wdata_q;
    assign mst_w_strb_o  = strb_q;
    assign mst_w_last_o  = 1'b1;

    assign rsp_data_o    = rsp_data_q;
    assign rsp_excl_ok_o = rsp_excl_ok_q;
    assign rsp_err_o     = rsp_err_q;

    assign dbg_state_o   = state_q;

    // Slave must answer with our ID and a single last beat.
    r_protocol_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == S_R && mst_r_valid_i) |-> (mst_r_last_i && mst_r_id_i == ID_VAL));

    b_protocol_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == S_B && mst_b_valid_i) |-> (mst_b_id_i == ID_VAL));

endmodule

// File: tb/tb_axi_riscv_lrsc_initiator.sv
// Testbench for axi_riscv_lrsc_initiator: bus-level slave driver plus a response model.
module tb_axi_riscv_lrsc_initiator;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int IW = 4;
    localparam int EW = DW + 2;
    localparam int BUDGET = 60;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_excl_ok;
    logic          rsp_err;
    logic [AW-1:0] ar_addr;
    logic [IW-1:0] ar_id;
    logic [2:0]    ar_size;
    logic          ar_lock;
    logic          ar_valid;
    logic          ar_ready;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_last;
    logic [IW-1:0] r_id;
    logic          r_valid;
    logic          r_ready;
    logic [AW-1:0] aw_addr;
    logic [IW-1:0] aw_id;
    logic [2:0]    aw_size;
    logic          aw_lock;
    logic          aw_valid;
    logic          aw_ready;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          w_last;
    logic          w_valid;
    logic          w_ready;
    logic [1:0]    b_resp;
    logic [IW-1:0] b_id;
    logic          b_valid;
    logic          b_ready;
    logic [2:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        int ar_seen, aw_seen, w_seen;
        int ar_hs, r_hs, aw_hs, w_hs, b_hs;
        int ar_after, aw_after, w_after;
        int unstable, rsp_unstable, busy_ready, rsp_cycles, latency;
        logic [AW-1:0] ar_addr, aw_addr;
        logic [2:0] ar_size, aw_size;
        logic ar_lock, aw_lock, w_last;
        logic [DW-1:0] w_data, rsp_data;
        logic [SW-1:0] w_strb;
        logic rsp_excl, rsp_err, ready_at_req, ready_after, timeout;
    } obs_t;

    axi_riscv_lrsc_initiator #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH(IW),
        .AXI_ID(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_excl_ok_o(rsp_excl_ok), .rsp_err_o(rsp_err),
        .mst_ar_addr_o(ar_addr), .mst_ar_id_o(ar_id), .mst_ar_size_o(ar_size),
        .mst_ar_lock_o(ar_lock), .mst_ar_valid_o(ar_valid), .mst_ar_ready_i(ar_ready),
        .mst_r_data_i(r_data), .mst_r_resp_i(r_resp), .mst_r_last_i(r_last),
        .mst_r_id_i(r_id), .mst_r_valid_i(r_valid), .mst_r_ready_o(r_ready),
        .mst_aw_addr_o(aw_addr), .mst_aw_id_o(aw_id), .mst_aw_size_o(aw_size),
        .mst_aw_lock_o(aw_lock), .mst_aw_valid_o(aw_valid), .mst_aw_ready_i(aw_ready),
        .mst_w_data_o(w_data), .mst_w_strb_o(w_strb), .mst_w_last_o(w_last),
        .mst_w_valid_o(w_valid), .mst_w_ready_i(w_ready),
        .mst_b_resp_i(b_resp), .mst_b_id_i(b_id), .mst_b_valid_i(b_valid),
        .mst_b_ready_o(b_ready),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_size = '0;
        req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b1; r_id = '0;
        b_valid = 1'b0; b_resp = 2'b00; b_id = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // Expected {err, excl_ok, data} derived directly from the operation rules.
    function automatic bit is_rejected(input logic [1:0] op, input logic [AW-1:0] addr,
                                       input logic [2:0] size);
        longint unsigned bytes;
        bytes = 64'd1 << size;
        return (op >= 2'd2) && ((size > 3'd3) || ((addr % bytes) != 0));
    endfunction

    function automatic logic [EW-1:0] model_rsp(input logic [1:0] op, input logic [AW-1:0] addr,
                                                input logic [2:0] size, input logic [1:0] resp,
                                                input logic [DW-1:0] rdata);
        bit excl, rd, err, ok;
        logic [DW-1:0] d;
        excl = (op >= 2'd2);
        rd = (op == 2'd0) || (op == 2'd2);
        if (is_rejected(op, addr, size)) return {1'b1, 1'b0, {DW{1'b0}}};
        err = (resp >= 2'd2);
        ok = excl && (resp == 2'd1);
        d = rd ? rdata : '0;
        return {err, ok, d};
    endfunction

    // ---------------- driver: request + cycle-accurate slave ----------------
    task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [2:0] size,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [1:0] resp, input logic [DW-1:0] rdata,
                           input int ar_dly, input int aw_dly, input int w_dly,
                           input int r_dly, input int rsp_dly, output obs_t o);
        int ar_cyc, aw_cyc, w_cyc, rsp_cyc, r_wait, b_wait;
        bit r_pend, b_pend, r_drop, b_drop, b_armed, done;
        o = '{default: 0};
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0; rsp_cyc = 0; r_wait = 0; b_wait = 0;
        r_pend = 0; b_pend = 0; r_drop = 0; b_drop = 0; b_armed = 0; done = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_size = size;
        req_wdata = wdata; req_strb = strb;
        o.ready_at_req = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = AW'({$urandom, $urandom});
        for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
            // R (before AR so data never precedes the address handshake)
            if (r_drop) begin r_valid = 1'b0; r_drop = 0; end
            if (r_pend) begin
                if (r_wait >= r_dly) begin
                    r_valid = 1'b1; r_data = rdata; r_resp = resp; r_last = 1'b1; r_id = '0;
                    if (r_ready) begin o.r_hs++; r_pend = 0; r_drop = 1; end
                end else r_wait++;
            end
            // B
            if (b_drop) begin b_valid = 1'b0; b_drop = 0; end
            if (b_pend) begin
                if (b_wait >= r_dly) begin
                    b_valid = 1'b1; b_resp = resp; b_id = '0;
                    if (b_ready) begin o.b_hs++; b_pend = 0; b_drop = 1; end
                end else b_wait++;
            end
            // AR
            if (ar_valid) begin
                o.ar_seen++;
                if (o.ar_hs > 0) o.ar_after++;
                if (ar_cyc == 0) begin
                    o.ar_addr = ar_addr; o.ar_lock = ar_lock; o.ar_size = ar_size;
                end else if ({ar_addr, ar_lock, ar_size} !== {o.ar_addr, o.ar_lock, o.ar_size})
                    o.unstable++;
                ar_cyc++;
                ar_ready = (ar_cyc > ar_dly);
                if (ar_ready) begin o.ar_hs++; r_pend = 1; r_wait = 0; end
            end else ar_ready = 1'b0;
            // AW
            if (aw_valid) begin
                o.aw_seen++;
                if (o.aw_hs > 0) o.aw_after++;
                if (aw_cyc == 0) begin
                    o.aw_addr = aw_addr; o.aw_lock = aw_lock; o.aw_size = aw_size;
                end else if ({aw_addr, aw_lock, aw_size} !== {o.aw_addr, o.aw_lock, o.aw_size})
                    o.unstable++;
                aw_cyc++;
                aw_ready = (aw_cyc > aw_dly);
                if (aw_ready) o.aw_hs++;
            end else aw_ready = 1'b0;
            // W
            if (w_valid) begin
                o.w_seen++;
                if (o.w_hs > 0) o.w_after++;
                if (w_cyc == 0) begin
                    o.w_data = w_data; o.w_strb = w_strb; o.w_last = w_last;
                end else if ({w_data, w_strb, w_last} !== {o.w_data, o.w_strb, o.w_last})
                    o.unstable++;
                w_cyc++;
                w_ready = (w_cyc > w_dly);
                if (w_ready) o.w_hs++;
            end else w_ready = 1'b0;
            if (!b_armed && o.aw_hs > 0 && o.w_hs > 0) begin
                b_armed = 1; b_pend = 1; b_wait = 0;
            end
            // core response side
            if (rsp_valid) begin
                if (rsp_cyc == 0) begin
                    o.latency = cyc;
                    o.rsp_data = rsp_data; o.rsp_excl = rsp_excl_ok; o.rsp_err = rsp_err;
                end else if ({rsp_err, rsp_excl_ok, rsp_data} !== {o.rsp_err, o.rsp_excl, o.rsp_data})
                    o.rsp_unstable++;
                rsp_cyc++;
                rsp_ready = (rsp_cyc > rsp_dly);
                if (rsp_ready) done = 1;
            end else rsp_ready = 1'b0;
            if (req_ready) o.busy_ready++;
            if (!done) @(negedge clk);
        end
        o.rsp_cycles = rsp_cyc;
        o.timeout = !done;
        @(negedge clk);
        rsp_ready = 1'b0; ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        r_valid = 1'b0; b_valid = 1'b0;
        o.ready_after = req_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_valids got=%b exp=000000",
                     {ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid});
        end
        checks++;
        if ({rsp_err, rsp_excl_ok, rsp_data} !== {EW{1'b0}}) begin
            failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_err, rsp_excl_ok, rsp_data});
        end
    endtask

    task automatic test_lr();
        obs_t o;
        logic [EW-1:0] e;
        exp_q.push_back(model_rsp(2'd2, 64'h1000, 3'd3, 2'b01, 64'hDEAD));
        run_txn(2'd2, 64'h1000, 3'd3, '0, '0, 2'b01, 64'hDEAD, 0, 0, 0, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if ({o.rsp_err, o.rsp_excl, o.rsp_data} !== e) begin
            failures++; $display("FAIL lr_rsp got=%h exp=%h", {o.rsp_err, o.rsp_excl, o.rsp_data}, e);
        end
        checks++;
        if ({o.ar_hs, o.ar_lock, o.ar_addr, o.ar_size} !== {32'd1, 1'b1, 64'h1000, 3'd3}) begin
            failures++;
            $display("FAIL lr_ar got hs=%0d lock=%b addr=%h size=%0d exp hs=1 lock=1 addr=1000 size=3",
                     o.ar_hs, o.ar_lock, o.ar_addr, o.ar_size);
        end
        checks++;
        if (o.latency !== 3) begin
            failures++; $display("FAIL lr_latency got=%0d exp=3", o.latency);
        end
        checks++;
        if ({o.aw_seen, o.w_seen, o.timeout, o.ready_after} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL lr_misc got aw=%0d w=%0d to=%b rdy=%b exp aw=0 w=0 to=0 rdy=1",
                     o.aw_seen, o.w_seen, o.timeout, o.ready_after);
        end
    endtask

    task automatic test_sc_fail();
        obs_t o;
        logic [EW-1:0] e;
        exp_q.push_back(model_rsp(2'd3, 64'h1000, 3'd3, 2'b00, 64'h0));
        run_txn(2'd3, 64'h1000, 3'd3, 64'h55, 8'hFF, 2'b00, 64'h1234, 0, 0, 2, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if ({o.rsp_err, o.rsp_excl, o.rsp_data} !== e) begin
            failures++; $display("FAIL sc_rsp got=%h exp=%h", {o.rsp_err, o.rsp_excl, o.rsp_data}, e);
        end
        checks++;
        if ({o.aw_lock, o.aw_addr, o.w_data, o.w_strb, o.w_last} !== {1'b1, 64'h1000, 64'h55, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL sc_payload got lock=%b addr=%h data=%h strb=%h last=%b",
                     o.aw_lock, o.aw_addr, o.w_data, o.w_strb, o.w_last);
        end
        checks++;
        if ({o.aw_seen, o.w_seen, o.aw_after, o.w_after} !== {32'd1, 32'd3, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL sc_valid_drop got aw=%0d w=%0d aw_after=%0d w_after=%0d exp 1 3 0 0",
                     o.aw_seen, o.w_seen, o.aw_after, o.w_after);
        end
        checks++;
        if ({o.b_hs, o.ar_seen, o.unstable} !== {32'd1, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL sc_b got b=%0d ar=%0d unstable=%0d exp 1 0 0", o.b_hs, o.ar_seen, o.unstable);
        end
    endtask

    task automatic test_sc_misaligned();
        obs_t o;
        logic [EW-1:0] e;
        exp_q.push_back(model_rsp(2'd3, 64'h1004, 3'd3, 2'b01, 64'h0));
        run_txn(2'd3, 64'h1004, 3'd3, 64'h77, 8'hFF, 2'b01, 64'h0, 0, 0, 0, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if ({o.rsp_err, o.rsp_excl, o.rsp_data} !== e) begin
            failures++; $display("FAIL misal_rsp got=%h exp=%h", {o.rsp_err, o.rsp_excl, o.rsp_data}, e);
        end
        checks++;
        if ({o.aw_seen, o.w_seen, o.ar_seen} !== {32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL misal_traffic got aw=%0d w=%0d ar=%0d exp 0 0 0", o.aw_seen, o.w_seen, o.ar_seen);
        end
        checks++;
        if (o.latency < 1 || o.latency > 2) begin
            failures++; $display("FAIL misal_latency got=%0d exp=1..2", o.latency);
        end
    endtask

    task automatic test_store_slverr();
        obs_t o;
        logic [EW-1:0] e;
        exp_q.push_back(model_rsp(2'd1, 64'h2000, 3'd2, 2'b10, 64'h0));
        run_txn(2'd1, 64'h2000, 3'd2, 64'hCAFE, 8'h0F, 2'b10, 64'hFFFF, 0, 0, 0, 1, 0, o);
        e = exp_q.pop_front();
        checks++;
        if ({o.rsp_err, o.rsp_excl, o.rsp_data} !== e) begin
            failures++; $display("FAIL store_rsp got=%h exp=%h", {o.rsp_err, o.rsp_excl, o.rsp_data}, e);
        end
        checks++;
        if ({o.aw_lock, o.aw_seen, o.w_seen, o.b_hs} !== {1'b0, 32'd1, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL store_chan got lock=%b aw=%0d w=%0d b=%0d exp 0 1 1 1",
                     o.aw_lock, o.aw_seen, o.w_seen, o.b_hs);
        end
    endtask

    task automatic test_rsp_stall();
        obs_t o;
        logic [EW-1:0] e;
        logic [DW-1:0] rd;
        rd = {$urandom, $urandom};
        exp_q.push_back(model_rsp(2'd0, 64'h40, 3'd3, 2'b00, rd));
        run_txn(2'd0, 64'h40, 3'd3, '0, '0, 2'b00, rd, 1, 0, 0, 2, 5, o);
        e = exp_q.pop_front();
        checks++;
        if ({o.rsp_err, o.rsp_excl, o.rsp_data} !== e) begin
            failures++; $display("FAIL stall_rsp got=%h exp=%h", {o.rsp_err, o.rsp_excl, o.rsp_data}, e);
        end
        checks++;
        if ({o.rsp_unstable, o.busy_ready, o.rsp_cycles} !== {32'd0, 32'd0, 32'd6}) begin
            failures++;
            $display("FAIL stall_hold got unstable=%0d busy_ready=%0d rsp_cycles=%0d exp 0 0 6",
                     o.rsp_unstable, o.busy_ready, o.rsp_cycles);
        end
        checks++;
        if ({o.ready_at_req, o.ready_after, o.ar_lock} !== 3'b110) begin
            failures++;
            $display("FAIL stall_ready got at_req=%b after=%b lock=%b exp 1 1 0",
                     o.ready_at_req, o.ready_after, o.ar_lock);
        end
    endtask

    task automatic test_reset_mid_aww();
        obs_t o;
        logic [EW-1:0] e;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_addr = 64'h3000; req_size = 3'd3;
        req_wdata = 64'h99; req_strb = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({aw_valid, w_valid} !== 2'b11) begin
            failures++; $display("FAIL rst_aww_entry got=%b exp=11", {aw_valid, w_valid});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({aw_valid, w_valid} !== 2'b00) begin
            failures++; $display("FAIL rst_async_drop got=%b exp=00", {aw_valid, w_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, b_ready} !== 3'b100) begin
            failures++; $display("FAIL rst_release got=%b exp=100", {req_ready, rsp_valid, b_ready});
        end
        // the block must work normally afterwards
        exp_q.push_back(model_rsp(2'd2, 64'h3008, 3'd3, 2'b01, 64'hBEEF));
        run_txn(2'd2, 64'h3008, 3'd3, '0, '0, 2'b01, 64'hBEEF, 0, 0, 0, 0, 0, o);
        e = exp_q.pop_front();
        checks++;
        if ({o.rsp_err, o.rsp_excl, o.rsp_data} !== e) begin
            failures++; $display("FAIL rst_recover got=%h exp=%h", {o.rsp_err, o.rsp_excl, o.rsp_data}, e);
        end
    endtask

    task automatic test_random(input int n);
        obs_t o;
        logic [EW-1:0] e;
        logic [1:0] op, resp;
        logic [2:0] size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rd;
        logic [SW-1:0] st;
        bit bad, rdop;
        int exp_rd, exp_wr;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            size = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            addr = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % (64'd1 << size));
            resp = 2'($urandom_range(0, 3));
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            st = SW'($urandom);
            bad = is_rejected(op, addr, size);
            rdop = (op == 2'd0) || (op == 2'd2);
            exp_rd = (!bad && rdop) ? 1 : 0;
            exp_wr = (!bad && !rdop) ? 1 : 0;
            exp_q.push_back(model_rsp(op, addr, size, resp, rd));
            run_txn(op, addr, size, wd, st, resp, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), o);
            e = exp_q.pop_front();
            checks++;
            if ({o.rsp_err, o.rsp_excl, o.rsp_data} !== e) begin
                failures++;
                $display("FAIL rand_rsp[%0d] op=%0d got=%h exp=%h", i, op,
                         {o.rsp_err, o.rsp_excl, o.rsp_data}, e);
            end
            checks++;
            if ({o.ar_hs, o.r_hs, o.aw_hs, o.w_hs, o.b_hs} !==
                {exp_rd, exp_rd, exp_wr, exp_wr, exp_wr}) begin
                failures++;
                $display("FAIL rand_counts[%0d] got ar=%0d r=%0d aw=%0d w=%0d b=%0d exp rd=%0d wr=%0d",
                         i, o.ar_hs, o.r_hs, o.aw_hs, o.w_hs, o.b_hs, exp_rd, exp_wr);
            end
            checks++;
            if ({o.ar_after, o.aw_after, o.w_after, o.unstable, o.timeout} !=
                {32'd0, 32'd0, 32'd0, 32'd0, 1'b0}) begin
                failures++;
                $display("FAIL rand_proto[%0d] got after=%0d/%0d/%0d unstable=%0d to=%b", i,
                         o.ar_after, o.aw_after, o.w_after, o.unstable, o.timeout);
            end
            if (exp_rd == 1) begin
                checks++;
                if ({o.ar_addr, o.ar_size, o.ar_lock} !== {addr, size, (op == 2'd2)}) begin
                    failures++;
                    $display("FAIL rand_ar[%0d] got addr=%h size=%0d lock=%b exp addr=%h size=%0d lock=%b",
                             i, o.ar_addr, o.ar_size, o.ar_lock, addr, size, (op == 2'd2));
                end
            end
            if (exp_wr == 1) begin
                checks++;
                if ({o.aw_addr, o.aw_size, o.aw_lock, o.w_data, o.w_strb} !==
                    {addr, size, (op == 2'd3), wd, st}) begin
                    failures++;
                    $display("FAIL rand_aw[%0d] got addr=%h lock=%b data=%h strb=%h exp addr=%h lock=%b data=%h strb=%h",
                             i, o.aw_addr, o.aw_lock, o.w_data, o.w_strb, addr, (op == 2'd3), wd, st);
                end
            end
            checks++;
            if (o.ready_after !== 1'b1) begin
                failures++; $display("FAIL rand_ready_after[%0d] got=%b exp=1", i, o.ready_after);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        do_reset();
        test_reset();
        test_lr();
        test_sc_fail();
        test_sc_misaligned();
        test_store_slverr();
        test_rsp_stall();
        test_reset_mid_aww();
        test_random(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
